// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared states, digit-adjust constants and sizing helper for bin2bcd_seq
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    function automatic int min_digits(input int w);
        longint unsigned v;
        int d;
        v = (64'd1 << w) - 64'd1;
        for (d = 1; v >= 64'd10; d++) v = v / 64'd10;
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: add 3 to a BCD digit that is 5 or more, ahead of the doubling shift
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction so the doubled digit carries correctly into the next digit
    always_comb dout = (din >= 4'(BCD_ADJ_THRESH)) ? din + 4'(BCD_ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle double-dabble binary to BCD converter with valid/ready handshakes
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam bit OVF_POSSIBLE = min_digits(BIN_W) > DIGITS;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic                     neg_q, neg_d;
    logic                     ovf_q, ovf_d;
    logic [BCD_W-1:0]         obcd_q, obcd_d;
    logic                     oneg_q, oneg_d;
    logic                     oovf_q, oovf_d;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BIN_W-1:0]         mag;
    logic                     in_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.din(bcd_q[4*g +: 4]), .dout(bcd_adj[4*g +: 4]));
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = obcd_q;
    assign out_neg   = oneg_q;
    assign out_ovf   = oovf_q;

    // Next-state, datapath and result-capture logic; the result registers load on the last shift
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        obcd_d  = obcd_q;
        oneg_d  = oneg_q;
        oovf_d  = oovf_q;
        in_neg  = SIGNED_IN && in_bin[BIN_W-1];
        mag     = in_neg ? ~in_bin + BIN_W'(1) : in_bin;
        shifted = {bcd_adj, bin_q} << 1;
        if (state_q == IDLE && in_valid) begin
            state_d = SHIFT;
            bin_d   = mag;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            neg_d   = in_neg;
        end else if (state_q == SHIFT) begin
            ovf_d          = ovf_q | (OVF_POSSIBLE && bcd_adj[BCD_W-1]);
            {bcd_d, bin_d} = shifted;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                state_d = DONE;
                obcd_d  = shifted[BCD_W+BIN_W-1 -: BCD_W];
                oneg_d  = neg_q;
                oovf_d  = ovf_d;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            obcd_q  <= '0;
            oneg_q  <= 1'b0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            obcd_q  <= obcd_d;
            oneg_q  <= oneg_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule
